// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    // funct3 encodings of the M extension
    localparam logic [2:0] MDU_OP_MUL    = 3'b000;
    localparam logic [2:0] MDU_OP_MULH   = 3'b001;
    localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
    localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
    localparam logic [2:0] MDU_OP_DIV    = 3'b100;
    localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
    localparam logic [2:0] MDU_OP_REM    = 3'b110;
    localparam logic [2:0] MDU_OP_REMU   = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CALC  = 2'b01,
        S_FIXUP = 2'b10,
        S_DONE  = 2'b11
    } mdu_state_t;

    // Width of the iteration counter for a given operand width
    function automatic int mdu_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int MDU_CNT_W = mdu_cnt_w(MDU_WIDTH);

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath.
//   mode 0: radix-2 shift-add over {acc, lo}, lo holds the multiplier.
//   mode 1: restoring shift-subtract, acc is the partial remainder and
//           lo holds the dividend shifting out / quotient shifting in.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    // Compute both candidate step results and select by mode
    always_comb begin
        w_sum   = {1'b0, i_acc};
        w_shift = {i_acc, i_lo[WIDTH-1]};
        // The true difference is below 2^WIDTH whenever it is kept, so a
        // WIDTH-bit subtraction is exact.
        w_sub   = w_shift[WIDTH-1:0] - i_opnd;
        w_ge    = (w_shift >= {1'b0, i_opnd});
        o_acc   = i_acc;
        o_lo    = i_lo;
        if (i_mode == 1'b0) begin
            if (i_lo[0]) begin
                w_sum = {1'b0, i_acc} + {1'b0, i_opnd};
            end else begin
                w_sum = {1'b0, i_acc};
            end
            o_acc = w_sum[WIDTH:1];
            o_lo  = {w_sum[0], i_lo[WIDTH-1:1]};
        end else begin
            if (w_ge) begin
                o_acc = w_sub;
                o_lo  = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_shift[WIDTH-1:0];
                o_lo  = {i_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: FSM, operand latches,
// special-case detection, sign fix-up and the registered result.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = mdu_cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_t       r_state;
    mdu_state_t       w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic             r_neg;
    logic             r_neg_rem;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_div0;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_result;
    logic             w_accept;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_fix_result;

    assign busy   = r_busy;
    assign done   = r_done;
    assign Result = r_result;

    // Decode signedness, operand magnitudes and the early-exit cases
    always_comb begin
        case (op)
            MDU_OP_MULHU, MDU_OP_DIVU, MDU_OP_REMU: w_a_signed = 1'b0;
            default:                                w_a_signed = 1'b1;
        endcase
        w_b_signed = w_a_signed && (op != MDU_OP_MULHSU);
        w_sign_a   = w_a_signed && SrcA[WIDTH-1];
        w_sign_b   = w_b_signed && SrcB[WIDTH-1];
        if (w_sign_a) begin
            w_mag_a = ~SrcA + ONE_W;
        end else begin
            w_mag_a = SrcA;
        end
        if (w_sign_b) begin
            w_mag_b = ~SrcB + ONE_W;
        end else begin
            w_mag_b = SrcB;
        end
        // op[2] selects DIV*/REM*, op[0]=0 among those is the signed pair
        w_div0    = op[2] && (SrcB == {WIDTH{1'b0}});
        w_ovf     = op[2] && !op[0] && (SrcA == MIN_W) && (SrcB == {WIDTH{1'b1}});
        w_special = w_div0 || w_ovf;
        if (w_div0) begin
            if (op[1]) begin
                w_special_result = SrcA;
            end else begin
                w_special_result = {WIDTH{1'b1}};
            end
        end else if (w_ovf) begin
            if (op[1]) begin
                w_special_result = {WIDTH{1'b0}};
            end else begin
                w_special_result = MIN_W;
            end
        end else begin
            w_special_result = {WIDTH{1'b0}};
        end
    end

    assign w_accept = (r_state == S_IDLE) && start && !flush;

    // Single-iteration datapath shared by multiply and divide
    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_mode (r_op[2]),
        .i_acc  (r_acc),
        .i_lo   (r_lo),
        .i_opnd (r_opnd),
        .o_acc  (w_step_acc),
        .o_lo   (w_step_lo)
    );

    // Sign fix-up and half selection applied in FIXUP
    always_comb begin
        w_prod = {r_acc, r_lo};
        if (r_neg) begin
            w_prod_fix = ~w_prod + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            w_prod_fix = w_prod;
        end
        case (r_op)
            MDU_OP_MUL:  w_fix_result = w_prod_fix[WIDTH-1:0];
            MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU:
                         w_fix_result = w_prod_fix[2*WIDTH-1:WIDTH];
            MDU_OP_DIV, MDU_OP_DIVU: begin
                if (r_neg) begin
                    w_fix_result = ~r_lo + ONE_W;
                end else begin
                    w_fix_result = r_lo;
                end
            end
            default: begin
                if (r_neg_rem) begin
                    w_fix_result = ~r_acc + ONE_W;
                end else begin
                    w_fix_result = r_acc;
                end
            end
        endcase
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_special) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_CALC;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_next_state = S_FIXUP;
                end else begin
                    w_next_state = S_CALC;
                end
            end
            S_FIXUP: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            w_next_state = w_next_state;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand latches, iteration registers and counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= 3'b000;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc     <= {WIDTH{1'b0}};
            r_lo      <= {WIDTH{1'b0}};
            r_opnd    <= {WIDTH{1'b0}};
            r_cnt     <= {CW{1'b0}};
        end else if (w_accept) begin
            r_op      <= op;
            r_neg     <= w_sign_a ^ w_sign_b;
            r_neg_rem <= w_sign_a;
            r_acc     <= {WIDTH{1'b0}};
            r_cnt     <= CW'(WIDTH - 1);
            if (op[2]) begin
                r_lo   <= w_mag_a;
                r_opnd <= w_mag_b;
            end else begin
                r_lo   <= w_mag_b;
                r_opnd <= w_mag_a;
            end
        end else if (r_state == S_CALC) begin
            r_acc <= w_step_acc;
            r_lo  <= w_step_lo;
            if (r_cnt != {CW{1'b0}}) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Registered busy/done flags and the result, loaded on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {WIDTH{1'b0}};
        end else begin
            r_busy <= (w_next_state == S_CALC) || (w_next_state == S_FIXUP);
            r_done <= (w_next_state == S_DONE);
            if (w_next_state == S_DONE) begin
                if (r_state == S_FIXUP) begin
                    r_result <= w_fix_result;
                end else begin
                    r_result <= w_special_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, randomized ops
// against a 64-bit arithmetic reference model, and multi-cycle sequences.
module tb_mdu_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res;

    mdu_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M rules
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic signed [63:0] p;
        logic [63:0]        up;
        sa = 64'(signed'(a));
        sb = 64'(signed'(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 >= 3'd4 && b == 32'h0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op in the current cycle and follow it to its done pulse.
    // Returns in the done cycle; operands are scrambled after accept.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat_exp,
                          input logic hold);
        int   lat;
        logic busy_ok;
        start = 1'b1;
        op    = f3;
        SrcA  = a;
        SrcB  = b;
        tick();
        start = hold;
        op    = 3'($urandom);
        SrcA  = $urandom;
        SrcB  = $urandom;
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        start = 1'b0;
        check({name, "_done_seen"}, 32'(done), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(lat_exp));
        check({name, "_result"}, Result, exp);
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        check({name, "_busy_during"}, 32'(busy_ok), 32'd1);
        last_res = exp;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        SrcA  = 32'h0;
        SrcB  = 32'h0;
        last_res = 32'h0;

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[2]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       34};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34};
        vecs[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
        vecs[12] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[13] = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
        vecs[14] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h0,        34};

        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", Result, 32'h0);
        reset = 1'b0;
        tick();

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat, 1'b0);
            tick();
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rf;
            logic [31:0] ra;
            logic [31:0] rb;
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rnd%0d_op%0d", i, rf), rf, ra, rb,
                   ref_model(rf, ra, rb), ref_latency(rf, ra, rb), 1'b0);
            tick();
        end

        // Flush in the middle of a multiply: no done, Result unchanged
        begin
            logic [31:0] held;
            int          seen;
            held  = last_res;
            start = 1'b1;
            op    = 3'd0;
            SrcA  = 32'd1234;
            SrcB  = 32'd5678;
            tick();
            start = 1'b0;
            for (int k = 0; k < 9; k++) tick();
            check("flush_busy_before", 32'(busy), 32'd1);
            flush = 1'b1;
            tick();
            flush = 1'b0;
            check("flush_busy_after", 32'(busy), 32'd0);
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                if (done) seen++;
                tick();
            end
            check("flush_no_done", 32'(seen), 32'd0);
            check("flush_result_held", Result, held);
        end

        // start held high through the whole op: only one op runs
        run_op("hold", 3'd5, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        tick();
        check("hold_single_busy", 32'(busy), 32'd0);
        check("hold_single_done", 32'(done), 32'd0);

        // Back-to-back: start during done is ignored, re-assert next cycle
        run_op("b2b_first", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
        start = 1'b1;
        op    = 3'd6;
        SrcA  = 32'hFFFFFFF9;
        SrcB  = 32'd2;
        tick();
        check("b2b_ignored_busy", 32'(busy), 32'd0);
        check("b2b_ignored_done", 32'(done), 32'd0);
        run_op("b2b_second", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 1'b0);
        tick();

        // Reset in the middle of an op
        begin
            int seen;
            start = 1'b1;
            op    = 3'd0;
            SrcA  = 32'd9;
            SrcB  = 32'd9;
            tick();
            start = 1'b0;
            for (int k = 0; k < 19; k++) tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check("midreset_busy", 32'(busy), 32'd0);
            check("midreset_done", 32'(done), 32'd0);
            check("midreset_result", Result, 32'h0);
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                if (done || busy) seen++;
                tick();
            end
            check("midreset_quiet", 32'(seen), 32'd0);
        end

        run_op("after_reset", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
